// File: rtl/cnnip_arb_pkg.sv
// rtl/cnnip_arb_pkg.sv - shared tag type and defaults for the bank arbiter
package cnnip_arb_pkg;

  typedef enum logic {TAG_HOST = 1'b0, TAG_CORE = 1'b1} arb_tag_e;

  localparam int MAX_OUTS_DEFAULT = 4;

endpackage

// File: rtl/arb_tag_fifo.sv
// rtl/arb_tag_fifo.sv - synchronous FIFO of requester tags for outstanding reads
module arb_tag_fifo
  import cnnip_arb_pkg::*;
#(
  parameter int DEPTH = MAX_OUTS_DEFAULT
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_push,
  input  arb_tag_e i_push_tag,
  input  logic     i_pop,
  output logic     o_full,
  output logic     o_empty,
  output arb_tag_e o_head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  arb_tag_e       r_mem [DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_cnt;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_head    = r_mem[r_rptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage needs no reset: head is only consumed while the FIFO is non-empty.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_push_tag;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/bank_arbiter.sv
// rtl/bank_arbiter.sv - round-robin host/core arbiter for one memory bank
// Optional grant/conflict counters: BANK_ARB_PERF_CNT_EN
module bank_arbiter
  import cnnip_arb_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 32,
  parameter int MAX_OUTS = MAX_OUTS_DEFAULT
) (
  input  logic          clk_a,
  input  logic          arst_aq,
  input  logic          h_en,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_din,
  output logic          h_gnt,
  output logic          h_valid,
  output logic [DW-1:0] h_dout,
  input  logic          c_en,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_din,
  output logic          c_gnt,
  output logic          c_valid,
  output logic [DW-1:0] c_dout,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_din,
  input  logic          m_valid,
  input  logic [DW-1:0] m_dout,
  input  logic          err_clr,
  output logic          err
`ifdef BANK_ARB_PERF_CNT_EN
  ,
  output logic [31:0]   h_gnt_cnt,
  output logic [31:0]   c_gnt_cnt,
  output logic [31:0]   conflict_cnt
`endif
);

  arb_tag_e      r_last_grant;
  logic          r_m_en;
  logic          r_m_we;
  logic [AW-1:0] r_m_addr;
  logic [DW-1:0] r_m_din;
  logic          r_err;
  logic          w_full;
  logic          w_empty;
  arb_tag_e      w_head;
  logic          w_h_win;
  logic          w_c_win;
  logic          w_push;
  arb_tag_e      w_push_tag;
  logic          w_pop;

  // On conflict the requester that was not granted last wins.
  assign w_h_win = h_en & (~c_en | (r_last_grant == TAG_CORE));
  assign w_c_win = c_en & (~h_en | (r_last_grant == TAG_HOST));
  assign h_gnt   = w_h_win & ~w_full;
  assign c_gnt   = w_c_win & ~w_full;

  assign w_push     = (h_gnt & ~h_we) | (c_gnt & ~c_we);
  assign w_push_tag = c_gnt ? TAG_CORE : TAG_HOST;
  assign w_pop      = m_valid & ~w_empty;

  assign h_valid = w_pop & (w_head == TAG_HOST);
  assign c_valid = w_pop & (w_head == TAG_CORE);
  assign h_dout  = h_valid ? m_dout : '0;
  assign c_dout  = c_valid ? m_dout : '0;

  assign m_en   = r_m_en;
  assign m_we   = r_m_we;
  assign m_addr = r_m_addr;
  assign m_din  = r_m_din;
  assign err    = r_err;

  arb_tag_fifo #(.DEPTH(MAX_OUTS)) u_tag_fifo (
    .i_clk      (clk_a),
    .i_rst      (arst_aq),
    .i_push     (w_push),
    .i_push_tag (w_push_tag),
    .i_pop      (w_pop),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head     (w_head)
  );

  always_ff @(posedge clk_a or posedge arst_aq) begin
    if (arst_aq) begin
      r_last_grant <= TAG_CORE;
      r_m_en       <= 1'b0;
      r_m_we       <= 1'b0;
      r_m_addr     <= '0;
      r_m_din      <= '0;
    end else if (h_gnt) begin
      r_last_grant <= TAG_HOST;
      r_m_en       <= 1'b1;
      r_m_we       <= h_we;
      r_m_addr     <= h_addr;
      r_m_din      <= h_din;
    end else if (c_gnt) begin
      r_last_grant <= TAG_CORE;
      r_m_en       <= 1'b1;
      r_m_we       <= c_we;
      r_m_addr     <= c_addr;
      r_m_din      <= c_din;
    end else begin
      r_m_en <= 1'b0;
      r_m_we <= 1'b0;
    end
  end

  always_ff @(posedge clk_a or posedge arst_aq) begin
    if (arst_aq)                  r_err <= 1'b0;
    else if (err_clr)             r_err <= 1'b0;
    else if (m_valid & w_empty)   r_err <= 1'b1;
  end

`ifdef BANK_ARB_PERF_CNT_EN
  logic [31:0] r_h_gnt_cnt;
  logic [31:0] r_c_gnt_cnt;
  logic [31:0] r_conflict_cnt;

  always_ff @(posedge clk_a or posedge arst_aq) begin
    if (arst_aq || err_clr) begin
      r_h_gnt_cnt    <= '0;
      r_c_gnt_cnt    <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (h_gnt)        r_h_gnt_cnt    <= r_h_gnt_cnt + 32'd1;
      if (c_gnt)        r_c_gnt_cnt    <= r_c_gnt_cnt + 32'd1;
      if (h_en && c_en) r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign h_gnt_cnt    = r_h_gnt_cnt;
  assign c_gnt_cnt    = r_c_gnt_cnt;
  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_bank_arbiter.sv
// tb/tb_bank_arbiter.sv - directed self-checking bench for bank_arbiter
module tb_bank_arbiter;

  logic        clk_a = 1'b0;
  logic        arst_aq;
  logic        h_en, h_we, c_en, c_we, m_valid, err_clr;
  logic [15:0] h_addr, c_addr;
  logic [31:0] h_din, c_din, m_dout;
  logic        h_gnt, h_valid, c_gnt, c_valid, m_en, m_we, err;
  logic [31:0] h_dout, c_dout, m_din;
  logic [15:0] m_addr;
`ifdef BANK_ARB_PERF_CNT_EN
  logic [31:0] h_gnt_cnt, c_gnt_cnt, conflict_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk_a = ~clk_a;

  bank_arbiter dut (
    .clk_a   (clk_a),   .arst_aq (arst_aq),
    .h_en    (h_en),    .h_we    (h_we),    .h_addr (h_addr), .h_din (h_din),
    .h_gnt   (h_gnt),   .h_valid (h_valid), .h_dout (h_dout),
    .c_en    (c_en),    .c_we    (c_we),    .c_addr (c_addr), .c_din (c_din),
    .c_gnt   (c_gnt),   .c_valid (c_valid), .c_dout (c_dout),
    .m_en    (m_en),    .m_we    (m_we),    .m_addr (m_addr), .m_din (m_din),
    .m_valid (m_valid), .m_dout  (m_dout),
    .err_clr (err_clr), .err     (err)
`ifdef BANK_ARB_PERF_CNT_EN
    ,
    .h_gnt_cnt    (h_gnt_cnt),
    .c_gnt_cnt    (c_gnt_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_a);
    #1;
  endtask

  initial begin
    arst_aq = 1'b1;
    h_en = 0; h_we = 0; h_addr = '0; h_din = '0;
    c_en = 0; c_we = 0; c_addr = '0; c_din = '0;
    m_valid = 0; m_dout = '0; err_clr = 0;
    step(); step();
    #1;
    check("rst_h_gnt", h_gnt, 0);
    check("rst_c_gnt", c_gnt, 0);
    check("rst_m_en", m_en, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_err", err, 0);
    arst_aq = 1'b0;
    step();

    // Host single read of 0x0010
    h_en = 1; h_we = 0; h_addr = 16'h0010; #1;
    check("t1_h_gnt", h_gnt, 1);
    check("t1_c_gnt", c_gnt, 0);
    step();
    h_en = 0;
    check("t1_m_en", m_en, 1);
    check("t1_m_we", m_we, 0);
    check("t1_m_addr", m_addr, 16'h0010);
    m_valid = 1; m_dout = 32'hDEADBEEF; #1;
    check("t1_h_valid", h_valid, 1);
    check("t1_h_dout", h_dout, 32'hDEADBEEF);
    check("t1_c_valid", c_valid, 0);
    check("t1_c_dout", c_dout, 0);
    step();
    m_valid = 0; #1;
    check("t1_m_en_idle", m_en, 0);
    check("t1_err", err, 0);

    // Alternation after reset: host wins first conflict
    arst_aq = 1; #2; arst_aq = 0;
    step();
    h_en = 1; h_we = 1; h_addr = 16'h0100; h_din = 32'h11;
    c_en = 1; c_we = 1; c_addr = 16'h0200; c_din = 32'h22;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("t2_h_gnt%0d", i), h_gnt, (i % 2 == 0));
      check($sformatf("t2_c_gnt%0d", i), c_gnt, (i % 2 == 1));
      step();
      check($sformatf("t2_m_addr%0d", i), m_addr, (i % 2 == 0) ? 16'h0100 : 16'h0200);
    end
    h_en = 0; c_en = 0;
`ifdef BANK_ARB_PERF_CNT_EN
    check("t2_h_gnt_cnt", h_gnt_cnt, 3);
    check("t2_c_gnt_cnt", c_gnt_cnt, 3);
    check("t2_conflict_cnt", conflict_cnt, 6);
`endif
    step();

    // Core fills the tag FIFO; host blocked until the first response
    c_en = 1; c_we = 0;
    for (int i = 0; i < 4; i++) begin
      c_addr = 16'h0400 + 16'(i); #1;
      check($sformatf("t3_c_gnt%0d", i), c_gnt, 1);
      step();
    end
    c_en = 0; h_en = 1; h_we = 0; h_addr = 16'h0020; #1;
    check("t3_full_blk0", h_gnt, 0);
    step();
    check("t3_full_blk1", h_gnt, 0);
    m_valid = 1; m_dout = 32'hA; #1;
    check("t3_pop_same_cycle", h_gnt, 0);
    check("t3_c_valid", c_valid, 1);
    check("t3_c_dout", c_dout, 32'hA);
    step();
    m_valid = 0; #1;
    check("t3_unblock", h_gnt, 1);
    step();
    h_en = 0;
    check("t3_m_addr", m_addr, 16'h0020);
    for (int i = 0; i < 3; i++) begin
      m_valid = 1; m_dout = 32'hB0 + 32'(i); #1;
      check($sformatf("t3_drain_c%0d", i), c_valid, 1);
      check($sformatf("t3_drain_cd%0d", i), c_dout, 32'hB0 + 32'(i));
      step();
    end
    #1;
    check("t3_drain_h", h_valid, 1);
    check("t3_drain_hc", c_valid, 0);
    step();
    m_valid = 0;

    // Interleaved H,C,H reads, in-order responses
    h_en = 1; h_we = 0; h_addr = 16'h0031; #1;
    check("t4_g0", h_gnt, 1);
    step();
    h_en = 0; c_en = 1; c_we = 0; c_addr = 16'h0032; #1;
    check("t4_g1", c_gnt, 1);
    step();
    c_en = 0; h_en = 1; h_addr = 16'h0033; #1;
    check("t4_g2", h_gnt, 1);
    step();
    h_en = 0;
    m_valid = 1; m_dout = 32'h1; #1;
    check("t4_r0_hv", h_valid, 1);
    check("t4_r0_hd", h_dout, 32'h1);
    step();
    m_dout = 32'h2; #1;
    check("t4_r1_cv", c_valid, 1);
    check("t4_r1_hv", h_valid, 0);
    check("t4_r1_cd", c_dout, 32'h2);
    step();
    m_dout = 32'h3; #1;
    check("t4_r2_hv", h_valid, 1);
    check("t4_r2_hd", h_dout, 32'h3);
    step();
    m_valid = 0;

    // Host write: no tag pushed
    h_en = 1; h_we = 1; h_addr = 16'h0040; h_din = 32'h55; #1;
    check("t5_h_gnt", h_gnt, 1);
    step();
    h_en = 0; h_we = 0;
    check("t5_m_en", m_en, 1);
    check("t5_m_we", m_we, 1);
    check("t5_m_din", m_din, 32'h55);
    step();
    check("t5_m_we_idle", m_we, 0);
    check("t5_m_addr_hold", m_addr, 16'h0040);

    // Response with empty FIFO sets err; write pushed nothing
    m_valid = 1; m_dout = 32'h77; #1;
    check("t6_h_valid", h_valid, 0);
    check("t6_c_valid", c_valid, 0);
    check("t6_h_dout", h_dout, 0);
    step();
    m_valid = 0;
    check("t6_err_set", err, 1);
    err_clr = 1;
    step();
    err_clr = 0;
    check("t6_err_clr", err, 0);
    m_valid = 1; err_clr = 1;
    step();
    m_valid = 0; err_clr = 0;
    check("t6_clr_wins", err, 0);

    // Reset with a read outstanding: the late response is flagged
    h_en = 1; h_we = 0; h_addr = 16'h0050; #1;
    check("t7_h_gnt", h_gnt, 1);
    step();
    h_en = 0;
    arst_aq = 1; #2; arst_aq = 0;
    check("t7_m_en_rst", m_en, 0);
    m_valid = 1; m_dout = 32'h99; #1;
    check("t7_h_valid", h_valid, 0);
    step();
    m_valid = 0;
    check("t7_err", err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
